// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: multi-cycle IEEE-754 binary square root, round-to-nearest-even.
//
// Sits between operand issue and result writeback. The format is set by
// EXP_W/MANT_W (FP16 = 5/10, BF16 = 8/7, FP32 = 8/23). BITS_PER_CYCLE (1 or 2)
// sets how many root bits the restoring iteration produces per cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; aborts any operation in flight
//   in_valid     operand valid
//   in_ready     unit idle and able to accept (low while rst is high)
//   in_data      operand {sign, exp, frac}
//   out_valid    result valid, held until out_ready
//   out_ready    consumer accepts the result
//   out_data     result {sign, exp, frac}
//   out_invalid  invalid-operation flag (negative non-NaN operand)
//   out_inexact  result was rounded
//
// Latency: K+2 cycles for finite positive operands, where
// K = ceil((MANT_W+2)/BITS_PER_CYCLE). Specials take 1 cycle.
module fp_sqrt_iter #(
    parameter int EXP_W          = 5,
    parameter int MANT_W         = 10,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+MANT_W:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   out_data,
    output logic                    out_invalid,
    output logic                    out_inexact
);

    localparam int W     = EXP_W + MANT_W + 1;
    localparam int RW    = MANT_W + 2;               // hidden + fraction + guard
    localparam int REMW  = MANT_W + 4;
    localparam int K     = (RW + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int STEPS = K * BITS_PER_CYCLE;
    localparam int RADW  = 2 * STEPS;
    localparam int CW    = $clog2(K) + 1;
    localparam int EW    = EXP_W + 2;
    localparam int LZW   = $clog2(MANT_W + 1);

    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ROUND,
        DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [RADW-1:0]        rad_r;
    logic [REMW-1:0]        rem_r;
    logic [RW-1:0]          root_r;
    logic signed [EW-1:0]   rexp_r;

    assign in_ready = (state == IDLE) && !rst;

    // ------------------------------------------------------------------
    // Operand classification and normalisation
    // ------------------------------------------------------------------
    logic                   in_sign;
    logic [EXP_W-1:0]       in_exp;
    logic [MANT_W-1:0]      in_frac;
    logic                   exp_ones, exp_zero, frac_zero;
    logic                   is_nan, is_zero, is_inf, is_neg, is_special;
    logic [W-1:0]           special_data;
    logic                   special_invalid;

    assign in_sign   = in_data[W-1];
    assign in_exp    = in_data[W-2:MANT_W];
    assign in_frac   = in_data[MANT_W-1:0];
    assign exp_ones  = &in_exp;
    assign exp_zero  = ~|in_exp;
    assign frac_zero = ~|in_frac;

    assign is_nan          = exp_ones && !frac_zero;
    assign is_zero         = exp_zero && frac_zero;
    assign is_inf          = exp_ones && frac_zero;
    assign is_neg          = in_sign && !is_zero;
    assign is_special      = is_nan || is_zero || is_inf || is_neg;
    assign special_invalid = is_neg && !is_nan;
    // Zeros keep their sign; +inf passes through; everything else is NaN.
    assign special_data    = (is_nan || is_neg) ? QNAN : in_data;

    logic [LZW-1:0]         lz;
    logic                   lz_found;

    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int unsigned i = 0; i < MANT_W; i++) begin
            if (!lz_found) begin
                if (in_frac[MANT_W-1-i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz = lz + 1'b1;
                end
            end
        end
    end

    logic [LZW:0]           sub_shamt;
    logic [MANT_W:0]        norm_sig;
    logic signed [EW-1:0]   norm_e;
    logic signed [EW-1:0]   norm_half;
    logic [2*RW-1:0]        rad_init;

    assign sub_shamt = {1'b0, lz} + 1'b1;

    always_comb begin
        if (exp_zero) begin
            // Subnormal: the leading one lands in the hidden-bit position.
            norm_sig = {1'b0, in_frac} << sub_shamt;
            norm_e   = -BIAS - $signed({{(EW-LZW){1'b0}}, lz});
        end else begin
            norm_sig = {1'b1, in_frac};
            norm_e   = $signed({2'b00, in_exp}) - BIAS;
        end
    end

    // An odd exponent folds one factor of two into the significand; the
    // arithmetic shift then gives the same halved exponent either way.
    assign norm_half = norm_e >>> 1;
    assign rad_init  = norm_e[0] ? {norm_sig, 1'b0, {RW{1'b0}}}
                                 : {1'b0, norm_sig, {RW{1'b0}}};

    // ------------------------------------------------------------------
    // Restoring square-root steps, BITS_PER_CYCLE chained per cycle.
    // The radicand is zero-extended at the top to a whole number of
    // cycles; leading zero pairs only shift a zero through the root.
    // ------------------------------------------------------------------
    logic [REMW-1:0]        rem_v;
    logic [RW-1:0]          root_v;
    logic [RADW-1:0]        rad_v;
    logic [REMW-1:0]        rem_sh;
    logic [REMW-1:0]        trial;

    always_comb begin
        rem_v  = rem_r;
        root_v = root_r;
        rad_v  = rad_r;
        rem_sh = '0;
        trial  = '0;
        for (int unsigned s = 0; s < BITS_PER_CYCLE; s++) begin
            rem_sh = {rem_v[REMW-3:0], rad_v[RADW-1 -: 2]};
            rad_v  = rad_v << 2;
            trial  = {root_v, 2'b01};
            if (rem_sh >= trial) begin
                rem_v  = rem_sh - trial;
                root_v = {root_v[RW-2:0], 1'b1};
            end else begin
                rem_v  = rem_sh;
                root_v = {root_v[RW-2:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Round to nearest even
    // ------------------------------------------------------------------
    logic                   guard, sticky, round_up, carry;
    logic [MANT_W:0]        frac_sum;
    logic signed [EW-1:0]   rnd_exp;
    logic [W-1:0]           rnd_data;

    assign guard    = root_r[0];
    assign sticky   = |rem_r;
    assign round_up = guard && (sticky || root_r[1]);
    assign frac_sum = {1'b0, root_r[MANT_W:1]} + {{MANT_W{1'b0}}, round_up};
    assign carry    = frac_sum[MANT_W];
    assign rnd_exp  = rexp_r + BIAS + $signed({{(EW-1){1'b0}}, carry});
    assign rnd_data = {1'b0, rnd_exp[EXP_W-1:0], frac_sum[MANT_W-1:0]};

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rad_r       <= '0;
            rem_r       <= '0;
            root_r      <= '0;
            rexp_r      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_special) begin
                            out_data    <= special_data;
                            out_invalid <= special_invalid;
                            out_inexact <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            rad_r  <= RADW'(rad_init);
                            rem_r  <= '0;
                            root_r <= '0;
                            rexp_r <= norm_half;
                            cnt    <= '0;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    rad_r  <= rad_v;
                    rem_r  <= rem_v;
                    root_r <= root_v;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(K - 1)) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out_data    <= rnd_data;
                    out_invalid <= 1'b0;
                    out_inexact <= guard || sticky;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb_fp_sqrt_iter: directed-vector bench for fp_sqrt_iter.
// Unit 0 is the FP16 default build; units 1..3 are FP16 radix-4, BF16
// radix-4 and FP32 builds sharing clock and reset.
module tb_fp_sqrt_iter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        iv   [4];
    logic        ir   [4];
    logic        ov   [4];
    logic        ordy [4];
    logic        oinv [4];
    logic        oinx [4];
    logic [15:0] d0, o0, d1, o1, d2, o2;
    logic [31:0] d3, o3;

    fp_sqrt_iter dut (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d0),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(o0),
        .out_invalid(oinv[0]), .out_inexact(oinx[0])
    );

    fp_sqrt_iter #(.EXP_W(5), .MANT_W(10), .BITS_PER_CYCLE(2)) dut_h2 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d1),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(o1),
        .out_invalid(oinv[1]), .out_inexact(oinx[1])
    );

    fp_sqrt_iter #(.EXP_W(8), .MANT_W(7), .BITS_PER_CYCLE(2)) dut_bf (
        .clk(clk), .rst(rst),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(d2),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(o2),
        .out_invalid(oinv[2]), .out_inexact(oinx[2])
    );

    fp_sqrt_iter #(.EXP_W(8), .MANT_W(23), .BITS_PER_CYCLE(1)) dut_f32 (
        .clk(clk), .rst(rst),
        .in_valid(iv[3]), .in_ready(ir[3]), .in_data(d3),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(o3),
        .out_invalid(oinv[3]), .out_inexact(oinx[3])
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Issue one operand on unit u, then wait (bounded) for the result,
    // capture it and complete the output handshake.
    task automatic run_op(input int u, input logic [31:0] a,
                          output logic [31:0] r, output logic inv,
                          output logic inx, output int lat);
        int wait_n;
        wait_n = 0;
        while (!ir[u] && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        case (u)
            0:       d0 = a[15:0];
            1:       d1 = a[15:0];
            2:       d2 = a[15:0];
            default: d3 = a;
        endcase
        iv[u] = 1'b1;
        @(posedge clk); #1;
        iv[u] = 1'b0;
        lat = 1;
        while (!ov[u] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        case (u)
            0:       r = {16'h0, o0};
            1:       r = {16'h0, o1};
            2:       r = {16'h0, o2};
            default: r = o3;
        endcase
        inv = oinv[u];
        inx = oinx[u];
        ordy[u] = 1'b1;
        @(posedge clk); #1;
        ordy[u] = 1'b0;
    endtask

    typedef struct {
        int          unit;
        logic [31:0] a;
        logic [31:0] r;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV] = '{
        '{0, 32'h4400, 32'h4000, 1'b0, 1'b0, 14},  // 4.0
        '{0, 32'h0001, 32'h0C00, 1'b0, 1'b0, 14},  // 2^-24, even exponent subnormal
        '{0, 32'h0002, 32'h0DA8, 1'b0, 1'b1, 14},  // 2^-23, odd exponent subnormal
        '{0, 32'h4200, 32'h3EEE, 1'b0, 1'b1, 14},  // 3.0, rounds up
        '{0, 32'h4000, 32'h3DA8, 1'b0, 1'b1, 14},  // 2.0, rounds down
        '{0, 32'h3C00, 32'h3C00, 1'b0, 1'b0, 14},  // 1.0
        '{0, 32'h4880, 32'h4200, 1'b0, 1'b0, 14},  // 9.0
        '{0, 32'h7BFF, 32'h5BFF, 1'b0, 1'b1, 14},  // max normal
        '{0, 32'hC400, 32'hFE00, 1'b1, 1'b0, 1},   // -4.0
        '{0, 32'hFC00, 32'hFE00, 1'b1, 1'b0, 1},   // -inf
        '{0, 32'h8001, 32'hFE00, 1'b1, 1'b0, 1},   // negative subnormal
        '{0, 32'h7E01, 32'hFE00, 1'b0, 1'b0, 1},   // NaN
        '{0, 32'h8000, 32'h8000, 1'b0, 1'b0, 1},   // -0
        '{0, 32'h0000, 32'h0000, 1'b0, 1'b0, 1},   // +0
        '{0, 32'h7C00, 32'h7C00, 1'b0, 1'b0, 1},   // +inf
        '{1, 32'h4400, 32'h4000, 1'b0, 1'b0, 8},   // FP16 radix-4
        '{1, 32'h4200, 32'h3EEE, 1'b0, 1'b1, 8},
        '{2, 32'h4080, 32'h4000, 1'b0, 1'b0, 7},   // BF16 radix-4
        '{3, 32'h40000000, 32'h3FB504F3, 1'b0, 1'b1, 27}  // FP32
    };

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        inv, inx;
        int          lat;
        int          seen;

        for (int i = 0; i < 4; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", {31'h0, ov[0]}, 32'h0);
        check("rst out_data", {16'h0, o0}, 32'h0);
        check("rst out_invalid", {31'h0, oinv[0]}, 32'h0);
        check("rst out_inexact", {31'h0, oinx[0]}, 32'h0);
        check("rst in_ready", {31'h0, ir[0]}, 32'h0);
        rst = 1'b0;
        #1;
        check("in_ready after rst", {31'h0, ir[0]}, 32'h1);

        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].unit, tbl[i].a, r, inv, inx, lat);
            check($sformatf("u%0d %h data", tbl[i].unit, tbl[i].a), r, tbl[i].r);
            check($sformatf("u%0d %h invalid", tbl[i].unit, tbl[i].a), {31'h0, inv}, {31'h0, tbl[i].inv});
            check($sformatf("u%0d %h inexact", tbl[i].unit, tbl[i].a), {31'h0, inx}, {31'h0, tbl[i].inx});
            check($sformatf("u%0d %h latency", tbl[i].unit, tbl[i].a), lat, tbl[i].lat);
        end

        // Backpressure: hold the result for five cycles.
        d0 = 16'h4200;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        seen = 0;
        while (!ov[0] && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp out_valid", {31'h0, ov[0]}, 32'h1);
            check("bp out_data", {16'h0, o0}, 32'h3EEE);
            check("bp out_inexact", {31'h0, oinx[0]}, 32'h1);
            check("bp out_invalid", {31'h0, oinv[0]}, 32'h0);
            check("bp in_ready", {31'h0, ir[0]}, 32'h0);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check("bp release in_ready", {31'h0, ir[0]}, 32'h1);
        check("bp release out_valid", {31'h0, ov[0]}, 32'h0);

        // Reset in the middle of CALC discards the operation.
        d0 = 16'h4400;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid rst in_ready", {31'h0, ir[0]}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post rst in_ready", {31'h0, ir[0]}, 32'h1);
        check("post rst out_data", {16'h0, o0}, 32'h0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov[0]) seen = 1;
        end
        check("aborted op out_valid", seen, 0);

        run_op(0, 32'h4400, r, inv, inx, lat);
        check("after rst data", r, 32'h4000);
        check("after rst inexact", {31'h0, inx}, 32'h0);
        check("after rst latency", lat, 14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_sqrt_iter.md
# fp_sqrt_iter

Parametrised, multi-cycle IEEE-754 binary square-root unit with valid/ready handshakes and round-to-nearest-even. It is the successor to the FP16-only, truncating square-root datapath. It generalises the format through `EXP_W`/`MANT_W` and the radix through `BITS_PER_CYCLE`, and it adds rounding, exception flags and backpressure. The unit sits between the operand-issue stage and the result writeback stage of the FP pipeline.

## Interface
- `EXP_W`, 5, exponent field width; bias = 2^(EXP_W-1)-1.
- `MANT_W`, 10, stored fraction width. FP16 = 5/10, BF16 = 8/7, FP32 = 8/23.
- `BITS_PER_CYCLE`, 1, root bits produced per CALC cycle; legal values are 1 and 2.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: unit idle, can accept.
- `in_data` in EXP_W+MANT_W+1: operand {sign, exp, frac}.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_data` out EXP_W+MANT_W+1: result {sign, exp, frac}.
- `out_invalid` out 1: invalid-operation flag.
- `out_inexact` out 1: inexact flag.

## Operation
- **States.** IDLE, CALC, ROUND, DONE.
- **Accept.** An operand is accepted when `in_valid && in_ready`. `in_ready` = (state == IDLE) && !rst.
- **Classification at accept.** The operand is classified combinationally. The specials below load the result registers directly and go IDLE->DONE:
  - NaN input, or negative nonzero operand (including -inf): result is the canonical NaN {1, all-ones exp, frac MSB 1, rest 0}.
  - `out_invalid` = 1 only for the negative non-NaN cases.
  - ±0 -> same signed zero. +inf -> +inf.
  - All specials have `out_inexact` = 0.
- **Finite positive operands.** These are normalised at accept.
  - Normal: significand is {1, frac}, unbiased exponent e = exp - bias.
  - Subnormal: frac is shifted left by clz+1, and e = 1 - bias - (clz+1).
  - e is held signed in EXP_W+2 bits.
  - If e is odd, the significand is shifted left one place and e is decremented.
  - Result exponent = e >>> 1 (arithmetic shift).
- **CALC.** Restoring digit-by-digit square root.
  - Each step shifts the next 2 radicand bits into the remainder.
  - Trial value = {root, 01}. Subtract and set the root bit to 1 when remainder >= trial; otherwise keep the remainder and set the root bit to 0.
  - Root width is MANT_W+2: hidden bit, MANT_W fraction bits and a guard bit.
  - Remainder width is MANT_W+4. Radicand width is 2*(MANT_W+2).
  - `BITS_PER_CYCLE` steps are chained per cycle. CALC lasts K = ceil((MANT_W+2)/BITS_PER_CYCLE) cycles, counted by an iteration counter.
- **ROUND.** One cycle.
  - guard = root LSB; sticky = (remainder != 0).
  - Round up when guard && (sticky || fraction LSB).
  - If the fraction carries out, it becomes 0 and the exponent is incremented.
  - Biased exponent = exponent + bias. The result is never subnormal and never overflows.
  - `out_inexact` = guard | sticky. `out_invalid` = 0.
- **DONE.** `out_valid` = 1.
  - `out_data` and both flags are held stable until `out_ready`.
  - On `out_valid && out_ready`, the next state is IDLE. No accept can happen in the same cycle, because `in_ready` = 0 in DONE.
- **Reset.** Takes priority in any state, including mid-CALC: the next state is IDLE and the in-flight operation is discarded.
  - Reset values: `out_valid` = 0, `out_data` = 0, `out_invalid` = 0, `out_inexact` = 0, iteration counter = 0.
  - `in_ready` = 0 while `rst` is high.

## Timing
- **Finite operand latency.** The operand is accepted at edge 0. `out_valid` rises after edge K+2 (K CALC cycles + 1 ROUND cycle + 1 accept-to-CALC cycle).
  - FP16 with `BITS_PER_CYCLE` = 1: K = 12, latency 14.
  - FP16 with `BITS_PER_CYCLE` = 2: K = 6, latency 8.
- **Special operand latency.** `out_valid` rises after edge 1 (latency 1).
- **Throughput.** At most one operation per latency+1 cycles when `out_ready` is held high.
- **Registered outputs.** All outputs are registered; none depends combinationally on `in_valid`, `in_data` or `out_ready`.
- **After reset.** In the first cycle after `rst` falls, `in_ready` = 1.

## Test plan
- FP16 defaults, `0x4400` (4.0) -> `0x4000` with both flags 0, `out_valid` exactly 14 cycles after accept. `0x0001` (2^-24) -> `0x0C00`, exact.
- `0x4200` (3.0) -> `0x3EEE`, inexact 1; a truncating implementation would give `0x3EED`, so this checks round-up. `0x4000` -> `0x3DA8`, inexact 1.
- Specials, each with latency 1:
  - `0xC400` -> `0xFE00`, invalid 1.
  - `0xFC00` -> `0xFE00`, invalid 1.
  - `0x7E01` -> `0xFE00`, invalid 0.
  - `0x8000` -> `0x8000`.
  - `0x7C00` -> `0x7C00`.
- Backpressure: `out_ready` held low 5 cycles after `out_valid` -> data and flags stable, `in_ready` stays 0. When `out_ready` goes high, the next cycle is IDLE.
- Reset: assert `rst` for 1 cycle mid-CALC -> `out_valid` never rises for that operand. `in_ready` = 1 the cycle after `rst` falls. A new `0x4400` then completes normally.
- Other configurations:
  - `EXP_W`=8, `MANT_W`=7, `BITS_PER_CYCLE`=2: `0x4080` -> `0x4000` in 7 cycles.
  - `EXP_W`=8, `MANT_W`=23: `0x40000000` -> `0x3FB504F3`, inexact 1.
